image_frame_store: RTL and testbench
====================================

Name: image_frame_store

Overview:
- Memory-side responder for the pixel-processing engine's row/col/in_pix/out_we/out_pix interface.
- Holds one 64x64 24-bit image in place: the engine reads a pixel by address, and its writes land at that same address.
- Raster-streams the source image in before the engine runs, then streams the processed image out once filter_done is seen.
- Sits between the system stream fabric and the processing engine.

Parameters:
ADDR_W, 6, width of row and col; image is 2^ADDR_W x 2^ADDR_W pixels
PIX_W, 24, pixel width (R 23:16, G 15:8, B 7:0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  input stream pixel valid
s_ready  out  1  input stream ready
s_pix  in  PIX_W  input stream pixel, raster order (row-major, col fastest)
row  in  ADDR_W  engine row select
col  in  ADDR_W  engine column select
in_pix  out  PIX_W  pixel at [row,col] returned to engine
out_we  in  1  engine write enable
out_pix  in  PIX_W  engine write data for [row,col]
filter_done  in  1  engine completion flag (level)
proc_go  out  1  high while engine may run; top level uses it as engine enable
m_valid  out  1  output stream pixel valid
m_ready  in  1  output stream ready
m_pix  out  PIX_W  output stream pixel, raster order
m_last  out  1  high with final pixel [63,63]
frame_done  out  1  dump complete, sticky until rst

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Storage: 4096 x PIX_W array, index = row*64+col. Read is combinational; write is synchronous.
- Reset values: state=LOAD, idx=0, s_ready=1, proc_go=0, m_valid=0, m_last=0, frame_done=0. Array contents are not cleared.
- FSM states: LOAD, RUN, DUMP, DONE.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready: mem[idx]<=s_pix, idx++.
  - On the handshake at idx=4095: idx<=0, s_ready<=0, next state RUN.
- RUN:
  - proc_go=1; in_pix=mem[row*64+col], combinational, zero-cycle latency (engine sets row/col, then samples in_pix the next cycle).
  - out_we=1 writes out_pix to mem[row*64+col] on that edge.
  - On filter_done=1: proc_go<=0, next state DUMP, idx=0.
  - A write in the same cycle as filter_done is still committed.
- DUMP:
  - m_valid=1; m_pix=mem[idx], combinational; m_last=(idx==4095).
  - On m_valid&&m_ready: idx++.
  - On the handshake with m_last: m_valid<=0, frame_done<=1, next state DONE.
  - m_pix and m_last are held stable while m_ready=0.
- DONE: all handshakes idle, frame_done=1. Leaves only via rst.
- Outside RUN: out_we is ignored (no write), and in_pix still shows mem[row,col] (don't-care).
- Outside LOAD: s_ready=0, so s_valid is ignored.
- filter_done is ignored outside RUN. A filter_done already high on RUN entry causes an immediate move to DUMP (integration must reset the engine with rst).
- rst mid-LOAD/RUN/DUMP: return to LOAD, idx=0, partial data stays in the array and is overwritten by the next load.
- Counters: idx is 2*ADDR_W bits and wraps only via explicit reset to 0. There is no overflow path.

Decomposition:
- Shared package holds: state encoding constants (LOAD=0, RUN=1, DUMP=2, DONE=3), IMG_DIM=64, PIX_W=24, and the R/G/B field slice constants used by the engine.
- One sub-module, frame_ram: PIX_W x 4096, async read port plus one sync write port with a mux-selected address. The FSM and address mux stay in image_frame_store.

Test Plan:
- Load pixel value = idx (0x000000..0x000FFF) with s_valid always 1 -> s_ready drops exactly 4096 cycles after reset release; proc_go=1 the next cycle.
- In RUN, drive row=5,col=7 -> in_pix=0x000147 the same cycle; then out_we=1, out_pix=0xABCDEF -> next cycle in_pix=0xABCDEF.
- In LOAD, pulse out_we=1, out_pix=0xFFFFFF at row=0,col=0 -> mem[0] still holds the streamed value 0x000000.
- Assert filter_done; dump with m_ready toggling 1,0,1,0 -> 4096 beats in raster order; m_pix stable while stalled; m_last only on beat 4096 (value of [63,63]); frame_done=1 after.
- Assert rst at dump beat 100 -> m_valid=0, s_ready=1 next cycle; reload plus dump reproduces the new image exactly.
- Full loop with the processing engine on a random image -> streamed output equals the reference-model mirror+grayscale+sharpen result bit-exactly.

Source files
------------

// File: rtl/image_frame_store_pkg.sv
// Shared constants for the frame store and the pixel engine it serves.
package image_frame_store_pkg;

    localparam int IMG_DIM = 64;
    localparam int PIX_W   = 24;

    // Colour field positions inside a pixel.
    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/frame_ram.sv
// Single-image pixel storage: one combinational read port, one clocked write port.
module frame_ram #(
    parameter int AW = 12,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];

    // Commit one pixel per cycle when enabled.
    // NOTE: storage has no reset; contents survive rst and are simply overwritten by the next load.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/image_frame_store.sv
// In-place frame store: streams an image in, lets the engine read/modify it, streams it out.
module image_frame_store #(
    parameter int ADDR_W = 6,
    parameter int PIX_W  = image_frame_store_pkg::PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_pix,
    input  logic [ADDR_W-1:0] row,
    input  logic [ADDR_W-1:0] col,
    output logic [PIX_W-1:0]  in_pix,
    input  logic              out_we,
    input  logic [PIX_W-1:0]  out_pix,
    input  logic              filter_done,
    output logic              proc_go,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIX_W-1:0]  m_pix,
    output logic              m_last,
    output logic              frame_done
);

    import image_frame_store_pkg::*;

    localparam int              IDX_W    = 2 * ADDR_W;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               s_ready_q, s_ready_d;
    logic               proc_go_q, proc_go_d;
    logic               m_valid_q, m_valid_d;
    logic               m_last_q, m_last_d;
    logic               frame_done_q, frame_done_d;

    logic               s_hs;
    logic               m_hs;
    logic               ram_we;
    logic [IDX_W-1:0]   ram_waddr;
    logic [PIX_W-1:0]   ram_wdata;
    logic [IDX_W-1:0]   ram_raddr;
    logic [PIX_W-1:0]   ram_rdata;

    assign s_hs = s_valid && s_ready_q;
    assign m_hs = m_valid_q && m_ready;

    // Next-state and next-output logic for the load / run / dump sequence.
    always_comb begin
        // NOTE: every _d starts as its _q so paths that do not assign it hold state instead of inferring a latch.
        state_d      = state_q;
        idx_d        = idx_q;
        s_ready_d    = s_ready_q;
        proc_go_d    = proc_go_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        frame_done_d = frame_done_q;
        case (state_q)
            LOAD: begin
                if (s_hs) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d     = '0;
                        s_ready_d = 1'b0;
                        proc_go_d = 1'b1;
                        state_d   = RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (filter_done) begin
                    idx_d     = '0;
                    proc_go_d = 1'b0;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    state_d   = DUMP;
                end
            end
            DUMP: begin
                if (m_hs) begin
                    if (m_last_q) begin
                        m_valid_d    = 1'b0;
                        m_last_d     = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        m_last_d = ((idx_q + 1'b1) == IDX_LAST);
                    end
                end
            end
            DONE: begin
            end
        endcase
    end

    // Register FSM state, pixel index and all handshake/status outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= LOAD;
            idx_q        <= '0;
            s_ready_q    <= 1'b1;
            proc_go_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            s_ready_q    <= s_ready_d;
            proc_go_q    <= proc_go_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Steer the RAM ports: stream index while loading/dumping, engine address otherwise.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = idx_q;
        ram_wdata = s_pix;
        ram_raddr = {row, col};
        case (state_q)
            LOAD: ram_we = s_hs;
            RUN: begin
                ram_we    = out_we;
                ram_waddr = {row, col};
                ram_wdata = out_pix;
            end
            DUMP: ram_raddr = idx_q;
            DONE: begin
            end
        endcase
    end

    frame_ram #(
        .AW (IDX_W),
        .DW (PIX_W)
    ) u_frame_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign s_ready    = s_ready_q;
    assign proc_go    = proc_go_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign frame_done = frame_done_q;
    assign in_pix     = ram_rdata;
    assign m_pix      = ram_rdata;

endmodule

// File: tb/tb_image_frame_store.sv
// Randomised scoreboard bench for image_frame_store with a flat-array image model.
module tb_image_frame_store;

    localparam int NPIX = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_pix;
    logic [5:0]  row;
    logic [5:0]  col;
    logic [23:0] in_pix;
    logic        out_we;
    logic [23:0] out_pix;
    logic        filter_done;
    logic        proc_go;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_pix;
    logic        m_last;
    logic        frame_done;

    int          errors = 0;
    int          checks = 0;
    int          beat_cnt = 0;
    bit          stall_seen = 1'b0;
    logic [23:0] stall_pix;
    logic        stall_last;

    logic [23:0] model_mem [NPIX];
    logic [23:0] exp_q [$];

    always #5 clk = ~clk;

    image_frame_store dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_pix       (s_pix),
        .row         (row),
        .col         (col),
        .in_pix      (in_pix),
        .out_we      (out_we),
        .out_pix     (out_pix),
        .filter_done (filter_done),
        .proc_go     (proc_go),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_pix       (m_pix),
        .m_last      (m_last),
        .frame_done  (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted beat and checks stall stability.
    always @(negedge clk) begin
        logic [23:0] exp_p;
        if (!rst) begin
            if (stall_seen && m_valid) begin
                check("stall_pix", 32'(m_pix), 32'(stall_pix));
                check("stall_last", 32'(m_last), 32'(stall_last));
            end
            stall_seen = 1'b0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("dump_overrun", 32'(1), 32'(0));
                end else begin
                    exp_p = exp_q.pop_front();
                    check("dump_pix", 32'(m_pix), 32'(exp_p));
                    check("dump_last", 32'(m_last), 32'(exp_q.size() == 0));
                end
                beat_cnt++;
            end else if (m_valid) begin
                stall_seen = 1'b1;
                stall_pix  = m_pix;
                stall_last = m_last;
            end
        end else begin
            stall_seen = 1'b0;
        end
    end

    // All tasks start and end one time unit after a rising edge.
    task automatic load_frame(input bit gaps, input bit seq_pix, input bit poke_we);
        int i = 0;
        int guard = 0;
        logic [23:0] p;
        while (i < NPIX && guard < 20000) begin
            p       = seq_pix ? 24'(i) : 24'($urandom);
            s_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
            s_pix   = p;
            out_we  = poke_we && (i < 16);
            row     = 6'd0;
            col     = 6'd0;
            out_pix = 24'hFFFFFF;
            @(negedge clk);
            if (s_valid && s_ready) begin
                model_mem[i] = p;
                i++;
            end
            guard++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        out_we  = 1'b0;
        check("load_complete", 32'(i), 32'(NPIX));
        if (!gaps) check("load_cycles", 32'(guard), 32'(NPIX));
        @(negedge clk);
        check("run_s_ready", 32'(s_ready), 32'(0));
        check("run_proc_go", 32'(proc_go), 32'(1));
        @(posedge clk); #1;
    endtask

    task automatic run_engine(input int n);
        for (int k = 0; k < n; k++) begin
            row     = 6'($urandom);
            col     = 6'($urandom);
            out_we  = 1'($urandom_range(1));
            out_pix = 24'($urandom);
            @(negedge clk);
            check("run_in_pix", 32'(in_pix), 32'(model_mem[{row, col}]));
            if (out_we) model_mem[{row, col}] = out_pix;
            @(posedge clk); #1;
        end
        out_we = 1'b0;
    endtask

    task automatic finish_run();
        row         = 6'($urandom);
        col         = 6'($urandom);
        out_we      = 1'b1;
        out_pix     = 24'($urandom);
        filter_done = 1'b1;
        @(negedge clk);
        model_mem[{row, col}] = out_pix;
        for (int k = 0; k < NPIX; k++) exp_q.push_back(model_mem[k]);
        @(posedge clk); #1;
        filter_done = 1'b0;
        out_we      = 1'b0;
    endtask

    task automatic wait_dump(input bit toggle);
        int n = 0;
        int base = beat_cnt;
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (frame_done || n >= 12000) break;
            @(posedge clk); #1;
            if (toggle) m_ready = ~m_ready;
            n++;
        end
        check("dump_timeout", 32'(n < 12000), 32'(1));
        check("dump_beats", 32'(beat_cnt - base), 32'(NPIX));
        check("dump_q_empty", 32'(exp_q.size()), 32'(0));
        check("done_frame_done", 32'(frame_done), 32'(1));
        check("done_m_valid", 32'(m_valid), 32'(0));
        check("done_m_last", 32'(m_last), 32'(0));
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        rst = 1'b1; s_valid = 1'b0; s_pix = '0; row = '0; col = '0;
        out_we = 1'b0; out_pix = '0; filter_done = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'(1));
        check("rst_proc_go", 32'(proc_go), 32'(0));
        check("rst_m_valid", 32'(m_valid), 32'(0));
        check("rst_m_last", 32'(m_last), 32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame 1: sequential pixels, engine writes during LOAD must be dropped.
        load_frame(1'b0, 1'b1, 1'b1);
        row = 6'd5; col = 6'd7; out_we = 1'b0;
        @(negedge clk);
        check("in_pix_5_7", 32'(in_pix), 32'h000147);
        @(posedge clk); #1;
        row = 6'd0; col = 6'd0;
        @(negedge clk);
        check("load_we_ignored", 32'(in_pix), 32'h000000);
        @(posedge clk); #1;
        row = 6'd5; col = 6'd7; out_we = 1'b1; out_pix = 24'hABCDEF;
        model_mem[5*64+7] = 24'hABCDEF;
        @(posedge clk); #1;
        out_we = 1'b0;
        @(negedge clk);
        check("in_pix_written", 32'(in_pix), 32'hABCDEF);
        @(posedge clk); #1;
        run_engine(150);
        finish_run();
        wait_dump(1'b1);

        // DONE ignores every request.
        filter_done = 1'b1; s_valid = 1'b1; out_we = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("done_sticky", 32'(frame_done), 32'(1));
        check("done_no_valid", 32'(m_valid), 32'(0));
        check("done_no_ready", 32'(s_ready), 32'(0));
        check("done_no_go", 32'(proc_go), 32'(0));
        @(posedge clk); #1;
        filter_done = 1'b0; s_valid = 1'b0; out_we = 1'b0;

        // Frame 2: random image, reset in the middle of the dump.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        load_frame(1'b1, 1'b0, 1'b0);
        run_engine(40);
        finish_run();
        m_ready = 1'b1;
        base = beat_cnt;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((beat_cnt - base) < 100 && n < 1000);
        check("beat100_reached", 32'((beat_cnt - base) >= 100), 32'(1));
        #1;
        rst = 1'b1;
        m_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_m_valid", 32'(m_valid), 32'(0));
        check("midrst_s_ready", 32'(s_ready), 32'(1));
        check("midrst_frame_done", 32'(frame_done), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame 3: fresh random image after the aborted dump must come back exactly.
        load_frame(1'b1, 1'b0, 1'b0);
        run_engine(200);
        finish_run();
        wait_dump(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
